ws_frame_sched: RTL and testbench

- Frame-rate scheduler for the eight pixel-strip transmitters (ws2812b/ws2811 lanes) in the clk20 domain.
- On each frame tick, issues one-cycle start pulses to the enabled strips in strict ascending order, one at a time, and waits for each strip to finish.
- Owns the double-buffer bank select: a host swap request is applied only at a frame boundary, so no strip ever shows a torn frame.
- Replaces the direct toggle-to-start path, which started strips directly from the host with no pacing.

---
 rtl/ws_frame_sched_if.sv | 29 ++
 rtl/ws_frame_sched.sv | 141 ++++++++++++++
 tb/tb_ws_frame_sched.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ws_frame_sched_if.sv
// Scheduler bundle: host controls/status plus the per-strip start/busy handshake.
// master = scheduler side, slave = host and transmitter side.
interface ws_frame_sched_if #(
  parameter int unsigned NUM_STRIPS = 8
);
  logic                  enable;
  logic [NUM_STRIPS-1:0] strip_mask;
  logic [8:0]            leds_cfg;
  logic                  swap_req;
  logic                  clr_err;
  logic [NUM_STRIPS-1:0] busy;
  logic [NUM_STRIPS-1:0] start;
  logic                  bank;
  logic [8:0]            leds;
  logic                  swap_ack;
  logic [15:0]           frame_cnt;
  logic                  overrun;
  logic [NUM_STRIPS-1:0] dead_strip;

  modport master (
    input  enable, strip_mask, leds_cfg, swap_req, clr_err, busy,
    output start, bank, leds, swap_ack, frame_cnt, overrun, dead_strip
  );

  modport slave (
    output enable, strip_mask, leds_cfg, swap_req, clr_err, busy,
    input  start, bank, leds, swap_ack, frame_cnt, overrun, dead_strip
  );
endinterface

// File: rtl/ws_frame_sched.sv
// Frame-rate scheduler: starts enabled strips one at a time on each frame tick and
// applies host bank swaps only at frame boundaries.
module ws_frame_sched #(
  parameter int unsigned NUM_STRIPS   = 8,
  parameter int unsigned FRAME_DIV    = 333333,
  parameter int unsigned BUSY_TIMEOUT = 64
) (
  input logic               clk,
  input logic               rst,
  ws_frame_sched_if.master  bus
);
  localparam int unsigned IdxW = $clog2(NUM_STRIPS + 1);
  localparam int unsigned SelW = (NUM_STRIPS > 1) ? $clog2(NUM_STRIPS) : 1;
  localparam int unsigned ToW  = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StScan, StIssue, StWaitRise, StWaitFall, StDone} state_e;

  state_e                state_q;
  logic [23:0]           tick_cnt_q;
  logic [IdxW-1:0]       idx_q;
  logic [ToW-1:0]        to_q;
  logic [NUM_STRIPS-1:0] mask_q;
  logic [NUM_STRIPS-1:0] start_q;
  logic [NUM_STRIPS-1:0] dead_q;
  logic [8:0]            leds_q;
  logic [15:0]           frame_cnt_q;
  logic                  bank_q;
  logic                  swap_ack_q;
  logic                  pend_q;
  logic                  overrun_q;

  logic                  tick;
  logic [SelW-1:0]       sel;
  logic                  idx_end;
  logic                  cur_mask;
  logic                  cur_busy;

  assign tick     = bus.enable && (tick_cnt_q == 24'(FRAME_DIV - 1));
  assign sel      = idx_q[SelW-1:0];
  assign idx_end  = (idx_q == IdxW'(NUM_STRIPS));
  assign cur_mask = mask_q[sel];
  assign cur_busy = bus.busy[sel];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= '0;
    end else if (!bus.enable || tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + 24'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      to_q        <= '0;
      mask_q      <= '0;
      start_q     <= '0;
      dead_q      <= '0;
      leds_q      <= '0;
      frame_cnt_q <= '0;
      bank_q      <= 1'b0;
      swap_ack_q  <= 1'b0;
      pend_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      start_q    <= '0;
      swap_ack_q <= 1'b0;
      if (bus.swap_req) pend_q <= 1'b1;
      // Clears come first so a same-cycle set below takes priority.
      if (bus.clr_err) begin
        overrun_q <= 1'b0;
        dead_q    <= '0;
      end
      if (tick && (state_q != StIdle)) overrun_q <= 1'b1;

      unique case (state_q)
        StIdle: begin
          if (tick) begin
            leds_q  <= bus.leds_cfg;
            mask_q  <= bus.strip_mask;
            idx_q   <= '0;
            state_q <= StScan;
          end
        end
        StScan: begin
          if (idx_end) begin
            state_q <= StDone;
          end else if (!cur_mask) begin
            idx_q <= idx_q + 1'b1;
          end else begin
            start_q[sel] <= 1'b1;
            state_q      <= StIssue;
          end
        end
        StIssue: begin
          to_q    <= '0;
          state_q <= StWaitRise;
        end
        StWaitRise: begin
          if (cur_busy) begin
            state_q <= StWaitFall;
          end else if (to_q == ToW'(BUSY_TIMEOUT - 1)) begin
            dead_q[sel] <= 1'b1;
            idx_q       <= idx_q + 1'b1;
            state_q     <= StScan;
          end else begin
            to_q <= to_q + 1'b1;
          end
        end
        StWaitFall: begin
          if (!cur_busy) begin
            idx_q   <= idx_q + 1'b1;
            state_q <= StScan;
          end
        end
        StDone: begin
          frame_cnt_q <= frame_cnt_q + 16'd1;
          if (pend_q) begin
            bank_q     <= ~bank_q;
            swap_ack_q <= 1'b1;
            // A request landing in this very cycle is kept for the next frame.
            pend_q     <= bus.swap_req;
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.start      = start_q;
  assign bus.bank       = bank_q;
  assign bus.leds       = leds_q;
  assign bus.swap_ack   = swap_ack_q;
  assign bus.frame_cnt  = frame_cnt_q;
  assign bus.overrun    = overrun_q;
  assign bus.dead_strip = dead_q;
endmodule

// File: tb/tb_ws_frame_sched.sv
// Bench for ws_frame_sched: frame table plus reset and overrun sequences, start pulses
// checked against a queue of expected one-hot vectors.
module tb_ws_frame_sched;
  localparam int unsigned N = 8;
  localparam int LenA = 10;
  localparam int LenB = 30;

  typedef struct {
    logic [N-1:0] mask;
    logic [N-1:0] dead;
    logic [8:0]   leds;
    int           swaps;
    logic [15:0]  exp_cnt;
    logic         exp_bank;
    logic [N-1:0] exp_dead;
    int           exp_gap;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ws_frame_sched_if #(.NUM_STRIPS(N)) ifa ();
  ws_frame_sched_if #(.NUM_STRIPS(N)) ifb ();

  ws_frame_sched #(.NUM_STRIPS(N), .FRAME_DIV(100), .BUSY_TIMEOUT(64)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  ws_frame_sched #(.NUM_STRIPS(N), .FRAME_DIV(20), .BUSY_TIMEOUT(64)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  int           errors = 0;
  int           checks = 0;
  logic [N-1:0] exp_q [$];
  int           cyc = 0;
  int           first_start_cyc = 0;
  int           dead_rise_cyc = 0;
  bit           frame_started = 1'b0;
  logic [N-1:0] prev_dead = '0;
  int           age_a [N];
  int           age_b [N];
  logic [N-1:0] dead_a = '0;

  // Strip model: busy rises 2 cycles after start and stays up Len cycles; dead_a strips never rise.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        age_a[i] <= 0;
        age_b[i] <= 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (ifa.start[i]) age_a[i] <= 1;
        else if (age_a[i] == LenA + 1) age_a[i] <= 0;
        else if (age_a[i] != 0) age_a[i] <= age_a[i] + 1;
        if (ifb.start[i]) age_b[i] <= 1;
        else if (age_b[i] == LenB + 1) age_b[i] <= 0;
        else if (age_b[i] != 0) age_b[i] <= age_b[i] + 1;
      end
    end
  end

  always_comb begin
    ifa.busy = '0;
    ifb.busy = '0;
    for (int i = 0; i < N; i++) begin
      ifa.busy[i] = !dead_a[i] && (age_a[i] >= 2) && (age_a[i] <= LenA + 1);
      ifb.busy[i] = (age_b[i] >= 2) && (age_b[i] <= LenB + 1);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    vec_t vecs [4];
    int   acks;
    bit   got;
    int   prev_first;
    int   n;
    int   pulses;

    // Gaps are tick spacing plus the difference in skipped leading strips (one SCAN cycle each).
    vecs[0] = '{8'h05, 8'h00, 9'd30,  2, 16'd1, 1'b1, 8'h00, 0};
    vecs[1] = '{8'h08, 8'h08, 9'd300, 0, 16'd2, 1'b1, 8'h08, 103};
    vecs[2] = '{8'h00, 8'h00, 9'd5,   1, 16'd3, 1'b0, 8'h08, 0};
    vecs[3] = '{8'hA2, 8'h00, 9'd511, 1, 16'd4, 1'b1, 8'h08, 198};

    rst = 1'b1;
    ifa.enable = 1'b0; ifa.strip_mask = '0; ifa.leds_cfg = '0; ifa.swap_req = 1'b0;
    ifa.clr_err = 1'b0;
    ifb.enable = 1'b0; ifb.strip_mask = '0; ifb.leds_cfg = '0; ifb.swap_req = 1'b0;
    ifb.clr_err = 1'b0;

    fork
      forever begin
        @(negedge clk);
        cyc++;
        if (ifa.start != '0) begin
          if (!frame_started) begin
            first_start_cyc = cyc;
            frame_started = 1'b1;
          end
          if (exp_q.size() == 0) chk("start_unexpected", 32'(ifa.start), 32'd0);
          else chk("start_order", 32'(ifa.start), 32'(exp_q.pop_front()));
        end
        if (prev_dead == '0 && ifa.dead_strip != '0) dead_rise_cyc = cyc;
        prev_dead = ifa.dead_strip;
      end
    join_none

    repeat (3) @(negedge clk);
    chk("rst_start", 32'(ifa.start), 32'd0);
    chk("rst_bank", 32'(ifa.bank), 32'd0);
    chk("rst_leds", 32'(ifa.leds), 32'd0);
    chk("rst_swap_ack", 32'(ifa.swap_ack), 32'd0);
    chk("rst_frame_cnt", 32'(ifa.frame_cnt), 32'd0);
    chk("rst_overrun", 32'(ifa.overrun), 32'd0);
    chk("rst_dead", 32'(ifa.dead_strip), 32'd0);
    rst = 1'b0;
    ifa.enable = 1'b1;

    for (int i = 0; i < 4; i++) begin
      ifa.strip_mask = vecs[i].mask;
      ifa.leds_cfg = vecs[i].leds;
      dead_a = vecs[i].dead;
      prev_first = first_start_cyc;
      frame_started = 1'b0;
      for (int j = 0; j < int'(N); j++) if (vecs[i].mask[j]) exp_q.push_back(N'(1) << j);

      if (vecs[i].swaps > 0) begin
        if (vecs[i].mask != '0) begin
          got = 1'b0;
          for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk);
            got = (ifa.busy != '0);
          end
          chk("busy_seen", 32'(got), 32'd1);
        end
        for (int s = 0; s < vecs[i].swaps; s++) begin
          ifa.swap_req = 1'b1;
          @(negedge clk);
          ifa.swap_req = 1'b0;
          @(negedge clk);
        end
        chk("bank_held_mid_frame", 32'(ifa.bank), 32'(!vecs[i].exp_bank));
      end

      acks = 0;
      got = 1'b0;
      for (int c = 0; c < 300 && !got; c++) begin
        @(negedge clk);
        acks += int'(ifa.swap_ack);
        got = (ifa.frame_cnt == vecs[i].exp_cnt);
      end
      chk("frame_done", 32'(got), 32'd1);
      @(negedge clk);
      acks += int'(ifa.swap_ack);
      chk("swap_ack_count", 32'(acks), 32'(vecs[i].swaps > 0));
      chk("bank", 32'(ifa.bank), 32'(vecs[i].exp_bank));
      chk("dead_strip", 32'(ifa.dead_strip), 32'(vecs[i].exp_dead));
      chk("leds_latched", 32'(ifa.leds), 32'(vecs[i].leds));
      if (vecs[i].exp_gap != 0)
        chk("frame_gap", 32'(first_start_cyc - prev_first), 32'(vecs[i].exp_gap));
      if (vecs[i].dead != '0)
        chk("dead_latency", 32'((dead_rise_cyc - first_start_cyc >= 64) &&
                                (dead_rise_cyc - first_start_cyc <= 66)), 32'd1);
    end

    ifa.clr_err = 1'b1;
    @(negedge clk);
    ifa.clr_err = 1'b0;
    chk("dead_cleared", 32'(ifa.dead_strip), 32'd0);

    // Reset while strip 0 is mid-transmission.
    ifa.strip_mask = 8'h01;
    ifa.leds_cfg = 9'd7;
    dead_a = '0;
    exp_q.push_back(8'h01);
    got = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      got = ifa.busy[0];
    end
    chk("rst_test_busy_seen", 32'(got), 32'd1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_start", 32'(ifa.start), 32'd0);
    chk("midrst_bank", 32'(ifa.bank), 32'd0);
    chk("midrst_frame_cnt", 32'(ifa.frame_cnt), 32'd0);
    chk("midrst_leds", 32'(ifa.leds), 32'd0);
    exp_q.push_back(8'h01);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    got = 1'b0;
    while (!got && n < 300) begin
      @(negedge clk);
      n++;
      got = (ifa.start != '0);
    end
    chk("first_start_after_rst", 32'(n), 32'd101);
    got = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      got = (ifa.frame_cnt == 16'd1);
    end
    chk("frame_after_rst", 32'(got), 32'd1);
    ifa.enable = 1'b0;

    // Short frame period with long busy: ticks land mid-frame.
    ifb.strip_mask = 8'h01;
    ifb.leds_cfg = 9'd50;
    ifb.enable = 1'b1;
    pulses = 0;
    got = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      if (ifb.start != '0) pulses++;
      got = (ifb.frame_cnt == 16'd2);
    end
    ifb.enable = 1'b0;
    chk("ovr_two_frames", 32'(got), 32'd1);
    chk("ovr_start_pulses", 32'(pulses), 32'd2);
    chk("ovr_overrun_set", 32'(ifb.overrun), 32'd1);
    @(negedge clk);
    chk("ovr_frame_cnt", 32'(ifb.frame_cnt), 32'd2);
    ifb.clr_err = 1'b1;
    @(negedge clk);
    ifb.clr_err = 1'b0;
    chk("ovr_cleared", 32'(ifb.overrun), 32'd0);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
